// File: rtl/muxn_scan.sv
// muxn_scan: registered NCH-way channel mux with manual select and optional dwell-timed scanning.
// Scan mode, dwell counter and disabled-channel skipping exist only when MUXN_SCAN_EN is defined.
module muxn_scan #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 4,
    parameter int unsigned DWELL = 100,
    localparam int unsigned SELW = $clog2(NCH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_mode,
    input  logic [SELW-1:0]      i_s,
    input  logic [NCH*WIDTH-1:0] i_w,
    input  logic [NCH-1:0]       i_ch_en,
    output logic [WIDTH-1:0]     o_f,
    output logic [SELW-1:0]      o_sel,
    output logic                 o_valid,
    output logic                 o_switch
);

    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             valid_q, valid_d;
    logic             switch_q;
    logic             blank;

`ifdef MUXN_SCAN_EN
    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;
    logic [SELW-1:0] lo_sel, hi_sel, nxt_en;
    logic            have_lo, have_hi, cur_en;

    // Next enabled channel above sel_q, else wrap to the lowest enabled one.
    always_comb begin
        lo_sel  = '0;
        hi_sel  = '0;
        have_lo = 1'b0;
        have_hi = 1'b0;
        cur_en  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (i_ch_en[k]) begin
                if (!have_lo) begin
                    lo_sel  = SELW'(k);
                    have_lo = 1'b1;
                end
                if (!have_hi && (k > int'(sel_q))) begin
                    hi_sel  = SELW'(k);
                    have_hi = 1'b1;
                end
                if (sel_q == SELW'(k)) begin
                    cur_en = 1'b1;
                end
            end
        end
        nxt_en = have_hi ? hi_sel : lo_sel;
    end

    // run_q is low on the first scan edge so a freshly entered channel gets a full dwell.
    always_comb begin
        sel_d = i_s;
        cnt_d = '0;
        run_d = 1'b0;
        blank = 1'b0;
        if (i_mode) begin
            sel_d = sel_q;
            run_d = 1'b1;
            if (!have_lo) begin
                blank = 1'b1;
            end else if (!cur_en) begin
                sel_d = nxt_en;
            end else if (run_q) begin
                if (cnt_q == LAST) begin
                    sel_d = nxt_en;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = i_mode;
    assign sel_d       = i_s;
    assign blank       = 1'b0;
`endif

    // Out-of-range selects match no channel and so yield zero data, not valid.
    always_comb begin
        f_d     = '0;
        valid_d = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if ((sel_d == SELW'(k)) && !blank) begin
                f_d     = i_w[k*WIDTH +: WIDTH];
                valid_d = i_ch_en[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sel_q    <= '0;
            f_q      <= '0;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            f_q      <= f_d;
            valid_q  <= valid_d;
            switch_q <= (sel_d != sel_q);
        end
    end

    assign o_f      = f_q;
    assign o_sel    = sel_q;
    assign o_valid  = valid_q;
    assign o_switch = switch_q;

endmodule

// File: tb/tb_muxn_scan.sv
// Bench for muxn_scan: a 4-channel and a 5-channel instance checked every cycle against a
// behavioural model, plus directed literal checks; scan phases run only with MUXN_SCAN_EN.
module tb_muxn_scan;

`ifdef MUXN_SCAN_EN
    localparam bit ScanEn = 1'b1;
`else
    localparam bit ScanEn = 1'b0;
`endif
    localparam int D4 = 100;
    localparam int D5 = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [2:0]  s;
    logic [19:0] w;
    logic [4:0]  en;

    logic [3:0] f4, f5;
    logic [1:0] sel4;
    logic [2:0] sel5;
    logic       valid4, valid5, sw4, sw5;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit mvalid = 1'b0;

    always #5 clk = ~clk;

    muxn_scan #(.WIDTH(4), .NCH(4), .DWELL(D4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_s(s[1:0]), .i_w(w[15:0]),
        .i_ch_en(en[3:0]), .o_f(f4), .o_sel(sel4), .o_valid(valid4), .o_switch(sw4)
    );

    muxn_scan #(.WIDTH(4), .NCH(5), .DWELL(D5)) dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_s(s), .i_w(w),
        .i_ch_en(en), .o_f(f5), .o_sel(sel5), .o_valid(valid5), .o_switch(sw5)
    );

    typedef struct {
        int       sel;
        int       t0;      // edge at which the current channel's dwell began
        bit       started;
        logic [3:0] f;
        bit       valid;
        bit       sw;
    } mstate_t;

    mstate_t m4, m5;

    // Circular search starting just after sel; an out-of-range sel searches from channel 0.
    function automatic int next_on(input int nch, input int sel, input logic [4:0] e);
        int start;
        start = (sel < nch) ? sel + 1 : 0;
        for (int i = 0; i < nch; i++) begin
            int c;
            c = (start + i) % nch;
            if (e[c]) return c;
        end
        return sel;
    endfunction

    function automatic mstate_t step(input mstate_t m, input int nch, input int dwell,
                                     input int e, input logic rst, input logic md,
                                     input int sv, input logic [19:0] wv, input logic [4:0] ev);
        mstate_t r;
        int nxt;
        int n_on;
        bit none;
        r = m;
        if (!rst) begin
            r = '{sel: 0, t0: 0, started: 1'b0, f: 4'd0, valid: 1'b0, sw: 1'b0};
            return r;
        end
        n_on = 0;
        for (int i = 0; i < nch; i++) if (ev[i]) n_on++;
        none = 1'b0;
        nxt  = sv;
        if (ScanEn && md) begin
            nxt = m.sel;
            if (n_on == 0) begin
                none = 1'b1;
                r.t0 = e;
            end else if (!(m.sel < nch && ev[m.sel])) begin
                nxt  = next_on(nch, m.sel, ev);
                r.t0 = e;
            end else if (!m.started) begin
                r.t0 = e;
            end else if (e - m.t0 == dwell) begin
                nxt  = next_on(nch, m.sel, ev);
                r.t0 = e;
            end
            r.started = 1'b1;
        end else begin
            r.started = 1'b0;
        end
        r.sw  = (nxt != m.sel);
        r.sel = nxt;
        if (nxt < nch && !none) begin
            r.f     = wv[nxt*4 +: 4];
            r.valid = ev[nxt];
        end else begin
            r.f     = 4'd0;
            r.valid = 1'b0;
        end
        return r;
    endfunction

    // Model advances on each rising edge; outputs are compared on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            m4 = step(m4, 4, D4, edge_n, rst_n, mode, int'(s[1:0]), {4'b0, w[15:0]},
                      {1'b0, en[3:0]});
            m5 = step(m5, 5, D5, edge_n, rst_n, mode, int'(s), w, en);
            mvalid = 1'b1;
            @(negedge clk);
            checks++;
            if ({sel4, f4, valid4, sw4} !== {2'(m4.sel), m4.f, m4.valid, m4.sw}) begin
                errors++;
                $display("FAIL model_dut4 edge %0d: sel/f/valid/sw got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         edge_n, sel4, f4, valid4, sw4, m4.sel, m4.f, m4.valid, m4.sw);
            end
            checks++;
            if ({sel5, f5, valid5, sw5} !== {3'(m5.sel), m5.f, m5.valid, m5.sw}) begin
                errors++;
                $display("FAIL model_dut5 edge %0d: sel/f/valid/sw got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         edge_n, sel5, f5, valid5, sw5, m5.sel, m5.f, m5.valid, m5.sw);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] onehot [4];

    initial begin
        onehot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rst_n = 1'b0;
        mode  = 1'b0;
        s     = 3'd0;
        w     = 20'hF8421;
        en    = 5'b11111;
        tick(2);
        lit("reset_f", 32'(f4), 32'h0);
        lit("reset_sel", 32'(sel4), 32'h0);
        lit("reset_valid", 32'(valid4), 32'h0);
        lit("reset_switch", 32'(sw4), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            s = 3'(i);
            tick(1);
            lit("manual_f", 32'(f4), 32'(onehot[i]));
            lit("manual_sel", 32'(sel4), 32'(i));
            lit("manual_switch", 32'(sw4), (i != 0) ? 32'h1 : 32'h0);
            tick(2);
            lit("manual_switch_once", 32'(sw4), 32'h0);
            tick(97);
        end

`ifdef MUXN_SCAN_EN
        mode  = 1'b1;
        rst_n = 1'b0;
        tick(1);
        lit("scan_reset_sel", 32'(sel4), 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 401; k++) begin
            tick(1);
            if (k == 100) lit("scan_hold0", 32'(sel4), 32'h0);
            if (k == 101) lit("scan_to1", 32'(sel4), 32'h1);
            if (k == 101) lit("scan_sw1", 32'(sw4), 32'h1);
            if (k == 102) lit("scan_sw1_end", 32'(sw4), 32'h0);
            if (k == 150) lit("scan_valid", 32'(valid4), 32'h1);
            if (k == 201) lit("scan_to2", 32'(sel4), 32'h2);
            if (k == 301) lit("scan_to3", 32'(sel4), 32'h3);
            if (k == 401) lit("scan_to0", 32'(sel4), 32'h0);
        end

        en = 5'b01010;
        tick(1);
        lit("skip_to1", 32'(sel4), 32'h1);
        tick(100);
        lit("alt_to3", 32'(sel4), 32'h3);
        tick(50);
        en = 5'b00010;
        tick(1);
        lit("disable_cur_sel", 32'(sel4), 32'h1);
        lit("disable_cur_sw", 32'(sw4), 32'h1);
        tick(150);
        lit("single_hold", 32'(sel4), 32'h1);
        lit("single_nosw", 32'(sw4), 32'h0);

        en = 5'b00000;
        tick(1);
        lit("none_sel", 32'(sel4), 32'h1);
        lit("none_f", 32'(f4), 32'h0);
        lit("none_valid", 32'(valid4), 32'h0);
        tick(20);
        lit("none_hold", 32'(sel4), 32'h1);
        en = 5'b00100;
        tick(1);
        lit("reen_sel", 32'(sel4), 32'h2);
        lit("reen_f", 32'(f4), 32'h4);

        en = 5'b11111;
        tick(5);
        lit("pre_rst_sel", 32'(sel4), 32'h2);
        rst_n = 1'b0;
        tick(1);
        lit("midrst_out", {f4, 2'b0, sel4, 3'b0, valid4, 3'b0, sw4}, 32'h0);
        rst_n = 1'b1;
        tick(100);
        lit("post_rst_hold", 32'(sel4), 32'h0);
        tick(1);
        lit("post_rst_to1", 32'(sel4), 32'h1);

        mode = 1'b0;
        s    = 3'd3;
        tick(1);
        lit("m2s_manual", 32'(sel4), 32'h3);
        mode = 1'b1;
        tick(100);
        lit("m2s_dwell", 32'(sel4), 32'h3);
        tick(1);
        lit("m2s_next", 32'(sel4), 32'h0);
`else
        mode = 1'b1;
        s    = 3'd2;
        tick(1);
        lit("mode_ignored", 32'(sel4), 32'h2);
`endif

        mode = 1'b0;
        s    = 3'd7;
        tick(1);
        lit("oor_f5", 32'(f5), 32'h0);
        lit("oor_valid5", 32'(valid5), 32'h0);
        lit("oor_sel5", 32'(sel5), 32'h7);
        lit("wrap_f4", 32'(f4), 32'h8);
        en = 5'b11101;
        s  = 3'd1;
        tick(1);
        lit("dis_f4", 32'(f4), 32'h2);
        lit("dis_valid4", 32'(valid4), 32'h0);
`ifdef MUXN_SCAN_EN
        s = 3'd7;
        tick(1);
        mode = 1'b1;
        tick(1);
        lit("oor_scan_sel5", 32'(sel5), 32'h0);
`endif
        tick(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muxn_scan.md
# muxn_scan

Parametrised, registered N-channel multiplexer; successor to the fixed 4:1 4-bit combinational mux. Selects one of NCH WIDTH-bit channels either directly from a select input (manual mode) or by stepping automatically through enabled channels every DWELL cycles (scan mode). Output data and the select that produced it are registered together, so they are always coherent. Used as the channel front-end for display, LED and probe paths on the class board.

## Interface
- WIDTH, 4: bits per channel.
- NCH, 4: channel count, ≥2; need not be a power of two.
- DWELL, 100: scan-mode cycles per channel, ≥1.
- SELW (localparam), $clog2(NCH): select width.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous and active-low.
- i_mode  in  1  0 = manual, 1 = scan.
- i_s  in  SELW  manual select.
- i_w  in  NCH*WIDTH  flattened channel data; channel k = i_w[k*WIDTH +: WIDTH].
- i_ch_en  in  NCH  per-channel enable mask.
- o_f  out  WIDTH  selected channel data, registered.
- o_sel  out  SELW  channel currently driving o_f.
- o_valid  out  1  o_f carries enabled, in-range channel data.
- o_switch  out  1  one-cycle pulse when o_sel changes value.

## Operation
- Each cycle, compute next_sel. Register o_sel <= next_sel and o_f <= i_w[next_sel] on the same edge.
- o_f tracks live data changes on the held channel, with 1 cycle of latency.
- Reset (i_rst_n = 0 at an edge): o_f = 0, o_sel = 0, o_valid = 0, o_switch = 0, dwell counter = 0. Reset mid-scan discards scan position.
- Manual mode:
  - next_sel = i_s.
  - i_s ≥ NCH: o_f = 0, o_valid = 0, o_sel = i_s.
  - Disabled channel: o_f still shows channel data, but o_valid = 0.
- Scan mode, dwell counter 0..DWELL-1:
  - When the counter reaches DWELL-1, next_sel becomes the next enabled channel in ascending order, wrapping NCH-1 → 0, and the counter clears.
  - If the current channel is disabled, advance on the next edge without waiting for dwell to expire; the counter clears.
  - If exactly one channel is enabled, o_sel holds and o_switch stays 0.
  - If no channel is enabled: o_sel holds, o_f = 0, o_valid = 0, counter held at 0.
- Mode change manual → scan: scanning starts from the current o_sel, counter cleared; it dwells a full DWELL on that channel if enabled.
- Mode change scan → manual: o_sel follows i_s on the next edge.
- o_switch = 1 in the cycle where the new o_sel first appears; it is never set in the first cycle after reset.

## Timing
- Manual: i_s sampled at edge k → o_sel and o_f valid after edge k. Latency is 1 cycle.
- Scan, all enabled, reset released at edge 0: o_sel = 0 for edges 1..DWELL, then 1 at edge DWELL+1, and so on. Period NCH*DWELL.
- DWELL = 1: o_sel changes every cycle and o_switch is held high.
- i_ch_en is sampled each edge. Disabling the current channel causes a switch on the following edge.
- No combinational path from inputs to outputs.

## Configuration
- MUXN_SCAN_EN
  - Defined: scan mode, dwell counter and skip logic are compiled in.
  - Undefined: i_mode is ignored, the block is manual-only and the dwell counter is not synthesised. o_switch still pulses on i_s changes. Ports are unchanged.

## Test plan
- Manual, WIDTH = 4, NCH = 4, i_w = {1000, 0100, 0010, 0001}, all enabled; i_s steps 0..3 every 100 cycles → o_f = 0001, 0010, 0100, 1000, each 1 cycle after i_s changes; o_switch pulses once per step.
- Scan, DWELL = 100, all enabled → o_sel sequence 0,1,2,3,0 with changes at cycles 101, 201, 301, 401 after reset; o_valid = 1 throughout.
- Scan, i_ch_en = 1010 → o_sel alternates 1,3,1; disabling channel 3 mid-dwell → o_sel = 1 on the next edge with an o_switch pulse.
- Scan, i_ch_en = 0000 → o_f = 0, o_valid = 0, o_sel held; re-enabling channel 2 → o_sel = 2 on the next edge.
- NCH = 5, manual i_s = 7 → o_f = 0, o_valid = 0.
- i_rst_n low for 1 cycle mid-scan at o_sel = 2 → all outputs 0; scan restarts from channel 0 with a full dwell.
